lcd_pin_responder: RTL and testbench

Clocked responder for the XUPV5-LX110T character-LCD pin bundle (`lcd_pins_t`: `db[7:4]`, `rw`, `rs`, `e`); it is the LCD end of the link the LCD controller drives. It decodes E strobes into HD44780 byte writes, tracks 8-bit/4-bit bus mode, models the busy flag and the DDRAM address counter, and drives nibbles back on reads. It serves as the in-fabric stand-in for the panel in simulation and on-chip debug; `wr_*` feeds a scoreboard or a logic analyser.

---
 rtl/lcd_pin_responder.sv | 192 +++++++++++++++++++
 tb/tb_lcd_pin_responder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_pin_responder.sv
// lcd_pin_responder: LCD-side model of the HD44780 character-LCD pin bundle.
// Decodes E strobes into byte writes, tracks bus mode, busy flag and DDRAM address.
module lcd_pin_responder #(
    parameter int BUSY_CYCLES      = 2000,
    parameter int LONG_BUSY_CYCLES = 76000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] pins,
    output logic [3:0] db_rd,
    output logic       db_oe,
    output logic       wr_valid,
    output logic       wr_rs,
    output logic [7:0] wr_byte,
    output logic       busy,
    output logic [6:0] addr,
    output logic       err
);

    // pins layout (lcd_pins_t, MSB first): db[7:4], rw, rs, e
    localparam int MAXB = (LONG_BUSY_CYCLES > BUSY_CYCLES) ?
                          LONG_BUSY_CYCLES : BUSY_CYCLES;
    localparam int CW = $clog2(MAXB + 1);
    localparam logic [CW-1:0] SHORT_LD = CW'(BUSY_CYCLES - 1);
    localparam logic [CW-1:0] LONG_LD  = CW'(LONG_BUSY_CYCLES - 1);

    // BYTE_MODE: 8-bit bus; NIB_HI/NIB_LO: 4-bit bus, phase 0/1
    typedef enum logic [1:0] {
        BYTE_MODE = 2'd0,
        NIB_HI    = 2'd1,
        NIB_LO    = 2'd2
    } mode_e;

    logic [6:0]    p_q;
    mode_e         mode_q, mode_d;
    logic [3:0]    hi_q, hi_d;
    logic          hi_rs_q, hi_rs_d;
    logic          hi_rw_q, hi_rw_d;
    logic [7:0]    rd_byte_q, rd_byte_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic [6:0]    addr_q, addr_d;
    logic          err_q, err_d;
    logic          wr_valid_q, wr_valid_d;
    logic          wr_rs_q, wr_rs_d;
    logic [7:0]    wr_byte_q, wr_byte_d;

    logic       e_rise;
    logic       e_fall;
    logic [3:0] f_db;
    logic       f_rs;
    logic       f_rw;

    assign e_rise = pins[0] & ~p_q[0];
    assign e_fall = ~pins[0] & p_q[0];
    assign f_db   = p_q[6:3];
    assign f_rw   = p_q[2];
    assign f_rs   = p_q[1];

    // Strobe decode, busy countdown, address counter and read snapshot
    always_comb begin
        logic       done;
        logic [7:0] t_byte;
        logic       t_rs;
        logic       t_rw;
        logic       is_home;

        mode_d     = mode_q;
        hi_d       = hi_q;
        hi_rs_d    = hi_rs_q;
        hi_rw_d    = hi_rw_q;
        rd_byte_d  = rd_byte_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        addr_d     = addr_q;
        err_d      = err_q;
        wr_valid_d = 1'b0;
        wr_rs_d    = wr_rs_q;
        wr_byte_d  = wr_byte_q;
        done       = 1'b0;
        t_byte     = 8'h00;
        t_rs       = 1'b0;
        t_rw       = 1'b0;
        is_home    = 1'b0;

        if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            busy_d = 1'b0;
        end

        // Snapshot only on the first nibble of a read
        if (e_rise && pins[2] && mode_q != NIB_LO) begin
            rd_byte_d = pins[1] ? 8'h00 : {busy_q, addr_q};
        end

        if (e_fall) begin
            unique case (mode_q)
                BYTE_MODE: begin
                    done   = 1'b1;
                    t_byte = {f_db, 4'h0};
                    t_rs   = f_rs;
                    t_rw   = f_rw;
                    if (!f_rw && !f_rs && f_db == 4'b0010) begin
                        mode_d = NIB_HI;
                    end
                end
                NIB_HI: begin
                    hi_d    = f_db;
                    hi_rs_d = f_rs;
                    hi_rw_d = f_rw;
                    mode_d  = NIB_LO;
                end
                NIB_LO: begin
                    done   = 1'b1;
                    t_byte = {hi_q, f_db};
                    t_rs   = hi_rs_q;
                    t_rw   = hi_rw_q;
                    mode_d = NIB_HI;
                    if (f_rs != hi_rs_q || f_rw != hi_rw_q) begin
                        err_d = 1'b1;
                    end
                end
                default: mode_d = BYTE_MODE;
            endcase
        end

        is_home = !t_rs && (t_byte == 8'h01 || t_byte == 8'h02 ||
                            t_byte == 8'h03);

        if (done && !t_rw) begin
            wr_valid_d = 1'b1;
            wr_rs_d    = t_rs;
            wr_byte_d  = t_byte;
            if (busy_q) begin
                err_d = 1'b1;
            end
            cnt_d  = is_home ? LONG_LD : SHORT_LD;
            busy_d = 1'b1;
            if (t_rs) begin
                addr_d = addr_q + 7'd1;
            end else if (t_byte[7]) begin
                addr_d = t_byte[6:0];
            end else if (is_home) begin
                addr_d = 7'd0;
            end
        end
    end

    // State registers; reset drops any partial nibble and returns to 8-bit mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q        <= 7'd0;
            mode_q     <= BYTE_MODE;
            hi_q       <= 4'd0;
            hi_rs_q    <= 1'b0;
            hi_rw_q    <= 1'b0;
            rd_byte_q  <= 8'h00;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            addr_q     <= 7'd0;
            err_q      <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_rs_q    <= 1'b0;
            wr_byte_q  <= 8'h00;
        end else begin
            p_q        <= pins;
            mode_q     <= mode_d;
            hi_q       <= hi_d;
            hi_rs_q    <= hi_rs_d;
            hi_rw_q    <= hi_rw_d;
            rd_byte_q  <= rd_byte_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
            wr_valid_q <= wr_valid_d;
            wr_rs_q    <= wr_rs_d;
            wr_byte_q  <= wr_byte_d;
        end
    end

    assign db_rd    = (mode_q == NIB_LO) ? rd_byte_q[3:0] : rd_byte_q[7:4];
    assign db_oe    = p_q[2];
    assign wr_valid = wr_valid_q;
    assign wr_rs    = wr_rs_q;
    assign wr_byte  = wr_byte_q;
    assign busy     = busy_q;
    assign addr     = addr_q;
    assign err      = err_q;

endmodule

// File: tb/tb_lcd_pin_responder.sv
// tb_lcd_pin_responder: directed + random strobes against a
// transaction-level model with time-based busy tracking.
module tb_lcd_pin_responder;

    localparam int BC  = 40;
    localparam int LBC = 150;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] pins = 7'd0;
    logic [3:0] db_rd;
    logic       db_oe;
    logic       wr_valid;
    logic       wr_rs;
    logic [7:0] wr_byte;
    logic       busy;
    logic [6:0] addr;
    logic       err;

    lcd_pin_responder #(
        .BUSY_CYCLES(BC),
        .LONG_BUSY_CYCLES(LBC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pins(pins),
        .db_rd(db_rd),
        .db_oe(db_oe),
        .wr_valid(wr_valid),
        .wr_rs(wr_rs),
        .wr_byte(wr_byte),
        .busy(busy),
        .addr(addr),
        .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // Reference model: bus mode, nibble phase, address, sticky error,
    // last read snapshot, and the last cycle in which busy is high.
    bit         m4;
    bit         mph;
    logic [3:0] mhi;
    bit         mhrs;
    bit         mhrw;
    logic [6:0] maddr;
    bit         merr;
    logic [7:0] mrd;
    int         busy_last = -1;

    bit         pending = 0;
    bit         exp_wv;
    logic [7:0] exp_byte;
    bit         exp_rs;
    logic [8:0] seen[$];

    function automatic bit mbusy(int c);
        return c <= busy_last;
    endfunction

    function automatic void model_reset();
        m4 = 0; mph = 0; mhi = 0; mhrs = 0; mhrw = 0;
        maddr = 0; merr = 0; mrd = 0; busy_last = -1;
    endfunction

    function automatic void mfall(bit rs, bit rw, logic [3:0] d, int n);
        bit         done;
        logic [7:0] b;
        bit         trs;
        bit         trw;
        bit         home;
        done = 0; b = 0; trs = 0; trw = 0;
        exp_wv = 0;
        if (!m4) begin
            done = 1; b = {d, 4'h0}; trs = rs; trw = rw;
            if (!rw && !rs && d == 4'b0010) m4 = 1;
        end else if (!mph) begin
            mhi = d; mhrs = rs; mhrw = rw; mph = 1;
        end else begin
            mph = 0; done = 1; b = {mhi, d}; trs = mhrs; trw = mhrw;
            if (rs != mhrs || rw != mhrw) merr = 1;
        end
        if (done && !trw) begin
            home = !trs && (b inside {8'h01, 8'h02, 8'h03});
            exp_wv = 1; exp_byte = b; exp_rs = trs;
            if (mbusy(n)) merr = 1;
            busy_last = n + (home ? LBC : BC);
            if (trs) maddr = maddr + 7'd1;
            else if (b[7]) maddr = b[6:0];
            else if (home) maddr = 7'd0;
        end
    endfunction

    task automatic flush();
        if (pending) begin
            pending = 0;
            check("wr_valid", wr_valid, exp_wv);
            if (exp_wv) begin
                check("wr_byte", wr_byte, exp_byte);
                check("wr_rs", wr_rs, exp_rs);
            end
            if (wr_valid) seen.push_back({wr_rs, wr_byte});
            check("addr", addr, maddr);
            check("busy", busy, mbusy(cyc));
            check("err", err, merr);
        end
    endtask

    task automatic strobe(input bit rs, input bit rw, input logic [3:0] d,
                          input int hi = 1);
        int n;
        @(posedge clk);
        #1;
        pins = {d, rw, rs, 1'b1};
        if (rw && (!m4 || !mph)) mrd = rs ? 8'h00 : {mbusy(cyc), maddr};
        @(negedge clk);
        flush();
        repeat (hi - 1) begin
            @(posedge clk);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        pins[0] = 1'b0;
        n = cyc;
        @(negedge clk);
        check("db_oe", db_oe, rw);
        check("wr_quiet", wr_valid, 1'b0);
        if (rw) check("db_rd", db_rd, (m4 && mph) ? mrd[3:0] : mrd[7:4]);
        mfall(rs, rw, d, n);
        pending = 1;
    endtask

    task automatic wbyte(input bit rs, input bit rw, input logic [7:0] b,
                         input int hi = 1);
        strobe(rs, rw, b[7:4], hi);
        strobe(rs, rw, b[3:0], hi);
    endtask

    task automatic idle(input int k);
        bit had;
        repeat (k) begin
            @(posedge clk);
            #1;
            pins = 7'd0;
            @(negedge clk);
            had = pending;
            flush();
            if (!had) check("wr_idle", wr_valid, 1'b0);
            check("busy_t", busy, mbusy(cyc));
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        pins = 7'd0;
        pending = 0;
        #2;
        check("reset", {db_rd, db_oe, wr_valid, wr_rs, wr_byte, busy, addr, err},
              32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [8:0] init_exp [5];
    int         gap;
    int         hi;
    bit         rs;
    bit         rw;
    bit         flip;
    logic [7:0] b;

    initial begin
        init_exp = '{9'h030, 9'h030, 9'h030, 9'h020, 9'h141};
        model_reset();
        do_reset();

        // Init sequence then data 0x41
        repeat (3) begin
            strobe(0, 0, 4'b0011);
            idle(BC + 2);
        end
        strobe(0, 0, 4'b0010);
        idle(BC + 2);
        wbyte(1, 0, 8'h41);
        idle(BC + 3);
        check("init_cnt", seen.size(), 5);
        for (int i = 0; i < 5; i++) check("init_seq", seen[i], init_exp[i]);
        check("init_addr", addr, 7'd1);
        check("init_err", err, 1'b0);

        // Set address 0x7F then wrap on data write
        wbyte(0, 0, 8'hFF);
        idle(1);
        check("addr_7f", addr, 7'h7F);
        idle(BC + 2);
        wbyte(1, 0, 8'h5A);
        idle(1);
        check("addr_wrap", addr, 7'h00);
        idle(BC + 2);

        // Clear display from addr 5
        wbyte(0, 0, 8'h85);
        idle(BC + 2);
        wbyte(0, 0, 8'h01, 2);
        idle(LBC + 3);
        check("clr_addr", addr, 7'd0);

        // Busy-flag read 10 cycles after a write with addr=3
        wbyte(0, 0, 8'h83);
        idle(10);
        wbyte(0, 1, 8'h00);
        idle(1);
        check("bf_rd", mrd, 8'h83);
        idle(BC + 2);

        // Violations: write while busy, then rs mismatch
        wbyte(0, 0, 8'h06);
        wbyte(0, 0, 8'h06);
        idle(BC + 2);
        strobe(0, 0, 4'h0);
        strobe(1, 0, 4'h6);
        idle(BC + 2);
        check("err_sticky", err, 1'b1);

        // Reset after a phase-0 nibble
        strobe(1, 0, 4'h4);
        do_reset();
        seen.delete();
        strobe(0, 0, 4'b0101);
        idle(2);
        check("rst_byte", seen[0], 9'h050);
        idle(BC + 2);

        // Random traffic in 4-bit mode
        strobe(0, 0, 4'b0010);
        for (int i = 0; i < 250; i++) begin
            rs = 1'($urandom_range(0, 1));
            rw = ($urandom_range(0, 3) == 0);
            flip = ($urandom_range(0, 11) == 0);
            b = 8'($urandom);
            hi = $urandom_range(1, 3);
            gap = $urandom_range(0, 4);
            if ($urandom_range(0, 5) == 0) gap = BC + 3;
            strobe(rs, rw, b[7:4], hi);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 2));
            strobe(flip ? ~rs : rs, rw, b[3:0], hi);
            idle(gap);
        end
        idle(LBC + 3);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
